// File: rtl/ahb3lite_decoder_ctrl.sv
// AHB-Lite 4-slave address decoder with a data-phase response mux, a built-in
// default slave that answers disabled regions with a two-cycle ERROR, and a saturating error counter.
module ahb3lite_decoder_ctrl #(
  parameter logic [3:0] REGION_EN = 4'b1111,
  parameter int         ERR_CNT_W = 8
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  input  logic [31:0]          HRDATA_1,
  input  logic [31:0]          HRDATA_2,
  input  logic [31:0]          HRDATA_3,
  input  logic [31:0]          HRDATA_4,
  input  logic                 HRESP_1,
  input  logic                 HRESP_2,
  input  logic                 HRESP_3,
  input  logic                 HRESP_4,
  input  logic                 HREADYOUT_1,
  input  logic                 HREADYOUT_2,
  input  logic                 HREADYOUT_3,
  input  logic                 HREADYOUT_4,
  input  logic                 ERR_CLR,
  output logic                 HSEL_1,
  output logic                 HSEL_2,
  output logic                 HSEL_3,
  output logic                 HSEL_4,
  output logic [31:0]          HRDATA,
  output logic                 HRESP,
  output logic                 HREADY,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  typedef enum logic [2:0] {
    DSEL_NONE = 3'd0,
    DSEL_SLV1 = 3'd1,
    DSEL_SLV2 = 3'd2,
    DSEL_SLV3 = 3'd3,
    DSEL_SLV4 = 3'd4,
    DSEL_DEF  = 3'd5
  } dsel_t;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]           region_s;
  logic                 region_en_s;
  logic                 def_req_s;
  logic [3:0]           hsel_s;
  logic [31:0]          hrdata_s;
  logic                 hresp_s;
  logic                 hready_s;
  logic                 unused_s;

  dsel_t                dsel_q;
  dsel_t                dsel_d;
  ds_state_t            ds_state_q;
  logic                 ds_resp_q;
  logic                 ds_ready_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_d;

  assign region_s    = HADDR[31:30];
  assign region_en_s = REGION_EN[region_s];
  // A transfer to a disabled region only needs an ERROR when it is a real transfer.
  assign def_req_s   = !region_en_s && HTRANS[1];
  assign hsel_s      = REGION_EN & (4'b0001 << region_s);
  assign unused_s    = ^{HADDR[29:0], HTRANS[0]};

  assign HSEL_1  = hsel_s[0];
  assign HSEL_2  = hsel_s[1];
  assign HSEL_3  = hsel_s[2];
  assign HSEL_4  = hsel_s[3];
  assign HRDATA  = hrdata_s;
  assign HRESP   = hresp_s;
  assign HREADY  = hready_s;
  assign ERR_CNT = err_cnt_q;

  // Next data-phase owner; only advances when the current data phase completes.
  always_comb begin
    dsel_d = dsel_q;
    if (hready_s) begin
      if (region_en_s) begin
        case (region_s)
          2'd0:    dsel_d = DSEL_SLV1;
          2'd1:    dsel_d = DSEL_SLV2;
          2'd2:    dsel_d = DSEL_SLV3;
          2'd3:    dsel_d = DSEL_SLV4;
          default: dsel_d = DSEL_NONE;
        endcase
      end else if (def_req_s) begin
        dsel_d = DSEL_DEF;
      end else begin
        dsel_d = DSEL_NONE;
      end
    end else begin
      dsel_d = dsel_q;
    end
  end

  // Data-phase owner register.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel_q <= DSEL_NONE;
    end else begin
      dsel_q <= dsel_d;
    end
  end

  // Default-slave FSM; response/ready are registered alongside the state.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ds_state_q <= DS_IDLE;
      ds_resp_q  <= 1'b0;
      ds_ready_q <= 1'b1;
    end else begin
      case (ds_state_q)
        DS_ERR1: begin
          ds_state_q <= DS_ERR2;
          ds_resp_q  <= 1'b1;
          ds_ready_q <= 1'b1;
        end
        DS_IDLE, DS_ERR2: begin
          if (hready_s && def_req_s) begin
            ds_state_q <= DS_ERR1;
            ds_resp_q  <= 1'b1;
            ds_ready_q <= 1'b0;
          end else begin
            ds_state_q <= DS_IDLE;
            ds_resp_q  <= 1'b0;
            ds_ready_q <= 1'b1;
          end
        end
        default: begin
          ds_state_q <= DS_IDLE;
          ds_resp_q  <= 1'b0;
          ds_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Response mux keyed on the registered owner, not on the address being decoded.
  always_comb begin
    hrdata_s = 32'h0000_0000;
    hresp_s  = 1'b0;
    hready_s = 1'b1;
    case (dsel_q)
      DSEL_SLV1: begin
        hrdata_s = HRDATA_1;
        hresp_s  = HRESP_1;
        hready_s = HREADYOUT_1;
      end
      DSEL_SLV2: begin
        hrdata_s = HRDATA_2;
        hresp_s  = HRESP_2;
        hready_s = HREADYOUT_2;
      end
      DSEL_SLV3: begin
        hrdata_s = HRDATA_3;
        hresp_s  = HRESP_3;
        hready_s = HREADYOUT_3;
      end
      DSEL_SLV4: begin
        hrdata_s = HRDATA_4;
        hresp_s  = HRESP_4;
        hready_s = HREADYOUT_4;
      end
      DSEL_DEF: begin
        hrdata_s = 32'h0000_0000;
        hresp_s  = ds_resp_q;
        hready_s = ds_ready_q;
      end
      DSEL_NONE: begin
        hrdata_s = 32'h0000_0000;
        hresp_s  = 1'b0;
        hready_s = 1'b1;
      end
      default: begin
        hrdata_s = 32'h0000_0000;
        hresp_s  = 1'b0;
        hready_s = 1'b1;
      end
    endcase
  end

  // One count per completed ERROR; clear has priority and the count saturates.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (ERR_CLR) begin
      err_cnt_d = {ERR_CNT_W{1'b0}};
    end else if (hresp_s && hready_s && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_ONE;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error counter register.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      err_cnt_q <= {ERR_CNT_W{1'b0}};
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_ahb3lite_decoder_ctrl.sv
// Directed-vector bench: the driver queues hand-computed expectations, a negedge
// monitor pops one per cycle and compares against the decoder outputs.
module tb_ahb3lite_decoder_ctrl;

  logic        HCLK;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATA_1, HRDATA_2, HRDATA_3, HRDATA_4;
  logic        HRESP_1, HRESP_2, HRESP_3, HRESP_4;
  logic        HREADYOUT_1, HREADYOUT_2, HREADYOUT_3, HREADYOUT_4;
  logic        ERR_CLR;
  logic        HSEL_1, HSEL_2, HSEL_3, HSEL_4;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        HREADY;
  logic [7:0]  ERR_CNT;

  typedef struct packed {
    logic [15:0] idx;
    logic [3:0]  hsel;
    logic        rdy;
    logic        rsp;
    logic [31:0] rd;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_push = 0;

  ahb3lite_decoder_ctrl #(
    .REGION_EN (4'b0111),
    .ERR_CNT_W (8)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HRDATA_1    (HRDATA_1),
    .HRDATA_2    (HRDATA_2),
    .HRDATA_3    (HRDATA_3),
    .HRDATA_4    (HRDATA_4),
    .HRESP_1     (HRESP_1),
    .HRESP_2     (HRESP_2),
    .HRESP_3     (HRESP_3),
    .HRESP_4     (HRESP_4),
    .HREADYOUT_1 (HREADYOUT_1),
    .HREADYOUT_2 (HREADYOUT_2),
    .HREADYOUT_3 (HREADYOUT_3),
    .HREADYOUT_4 (HREADYOUT_4),
    .ERR_CLR     (ERR_CLR),
    .HSEL_1      (HSEL_1),
    .HSEL_2      (HSEL_2),
    .HSEL_3      (HSEL_3),
    .HSEL_4      (HSEL_4),
    .HRDATA      (HRDATA),
    .HRESP       (HRESP),
    .HREADY      (HREADY),
    .ERR_CNT     (ERR_CNT)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // One cycle of stimulus plus the outputs expected during that cycle.
  task automatic step(input logic rst, input logic [31:0] addr, input logic [1:0] trans,
                      input logic [3:0] rdy, input logic [3:0] rsp, input logic clr,
                      input logic [3:0] e_hsel, input logic e_rdy, input logic e_rsp,
                      input logic [31:0] e_rd, input logic [7:0] e_cnt);
    exp_t x;
    @(posedge HCLK);
    #1;
    HRESET = rst;
    HADDR = addr;
    HTRANS = trans;
    {HREADYOUT_4, HREADYOUT_3, HREADYOUT_2, HREADYOUT_1} = rdy;
    {HRESP_4, HRESP_3, HRESP_2, HRESP_1} = rsp;
    ERR_CLR = clr;
    x.idx  = n_push[15:0];
    x.hsel = e_hsel;
    x.rdy  = e_rdy;
    x.rsp  = e_rsp;
    x.rd   = e_rd;
    x.cnt  = e_cnt;
    sb.push_back(x);
    n_push++;
  endtask

  always @(negedge HCLK) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if ({HSEL_4, HSEL_3, HSEL_2, HSEL_1} !== e.hsel) begin
        n_err++;
        $display("FAIL hsel vec %0d: got %b want %b", e.idx, {HSEL_4, HSEL_3, HSEL_2, HSEL_1}, e.hsel);
      end
      if (HREADY !== e.rdy) begin
        n_err++;
        $display("FAIL hready vec %0d: got %b want %b", e.idx, HREADY, e.rdy);
      end
      if (HRESP !== e.rsp) begin
        n_err++;
        $display("FAIL hresp vec %0d: got %b want %b", e.idx, HRESP, e.rsp);
      end
      if (HRDATA !== e.rd) begin
        n_err++;
        $display("FAIL hrdata vec %0d: got %h want %h", e.idx, HRDATA, e.rd);
      end
      if (ERR_CNT !== e.cnt) begin
        n_err++;
        $display("FAIL err_cnt vec %0d: got %0d want %0d", e.idx, ERR_CNT, e.cnt);
      end
    end
  end

  initial begin
    HRESET = 1'b1;
    HADDR = 32'h0;
    HTRANS = 2'b00;
    HRDATA_1 = 32'h1111_1111;
    HRDATA_2 = 32'h2222_2222;
    HRDATA_3 = 32'h3333_3333;
    HRDATA_4 = 32'h4444_4444;
    {HRESP_4, HRESP_3, HRESP_2, HRESP_1} = 4'b0000;
    {HREADYOUT_4, HREADYOUT_3, HREADYOUT_2, HREADYOUT_1} = 4'b1111;
    ERR_CLR = 1'b0;
    @(posedge HCLK);

    // Reset and idle
    step(1'b1, 32'h0000_0000, 2'b00, 4'hF, 4'h0, 1'b0, 4'b0001, 1'b1, 1'b0, 32'h0, 8'd0);
    // Pipelined reads: data follows the registered owner
    step(1'b0, 32'h0000_0010, 2'b10, 4'hF, 4'h0, 1'b0, 4'b0001, 1'b1, 1'b0, 32'h0, 8'd0);
    step(1'b0, 32'h4000_0020, 2'b10, 4'hF, 4'h0, 1'b0, 4'b0010, 1'b1, 1'b0, 32'h1111_1111, 8'd0);
    step(1'b0, 32'h8000_0000, 2'b10, 4'hF, 4'h0, 1'b0, 4'b0100, 1'b1, 1'b0, 32'h2222_2222, 8'd0);
    // Slave 3 waits three cycles while the address moves to a disabled region
    step(1'b0, 32'hC000_0000, 2'b00, 4'b1011, 4'h0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h3333_3333, 8'd0);
    step(1'b0, 32'hC000_0000, 2'b00, 4'b1011, 4'h0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h3333_3333, 8'd0);
    step(1'b0, 32'hC000_0000, 2'b00, 4'b1011, 4'h0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h3333_3333, 8'd0);
    step(1'b0, 32'hC000_0000, 2'b00, 4'hF, 4'h0, 1'b0, 4'b0000, 1'b1, 1'b0, 32'h3333_3333, 8'd0);
    // Single default-slave error
    step(1'b0, 32'hC000_0004, 2'b10, 4'hF, 4'h0, 1'b0, 4'b0000, 1'b1, 1'b0, 32'h0, 8'd0);
    step(1'b0, 32'h0000_0000, 2'b00, 4'hF, 4'h0, 1'b0, 4'b0001, 1'b0, 1'b1, 32'h0, 8'd0);
    step(1'b0, 32'h0000_0000, 2'b00, 4'hF, 4'h0, 1'b0, 4'b0001, 1'b1, 1'b1, 32'h0, 8'd0);
    // Back-to-back default-slave errors, clear coincides with the second completion
    step(1'b0, 32'hC000_0000, 2'b10, 4'hF, 4'h0, 1'b0, 4'b0000, 1'b1, 1'b0, 32'h1111_1111, 8'd1);
    step(1'b0, 32'hC000_0000, 2'b10, 4'hF, 4'h0, 1'b0, 4'b0000, 1'b0, 1'b1, 32'h0, 8'd1);
    step(1'b0, 32'hC000_0000, 2'b10, 4'hF, 4'h0, 1'b0, 4'b0000, 1'b1, 1'b1, 32'h0, 8'd1);
    step(1'b0, 32'hC000_0000, 2'b00, 4'hF, 4'h0, 1'b0, 4'b0000, 1'b0, 1'b1, 32'h0, 8'd2);
    step(1'b0, 32'h8000_0000, 2'b10, 4'hF, 4'h0, 1'b1, 4'b0100, 1'b1, 1'b1, 32'h0, 8'd2);
    // Slave-originated error counts too
    step(1'b0, 32'h0000_0000, 2'b00, 4'hF, 4'b0100, 1'b0, 4'b0001, 1'b1, 1'b1, 32'h3333_3333, 8'd0);
    // Reset asserted while the default slave is in its first error cycle
    step(1'b0, 32'hC000_0000, 2'b10, 4'hF, 4'h0, 1'b0, 4'b0000, 1'b1, 1'b0, 32'h1111_1111, 8'd1);
    step(1'b1, 32'h0000_0000, 2'b00, 4'hF, 4'h0, 1'b0, 4'b0001, 1'b0, 1'b1, 32'h0, 8'd1);
    step(1'b0, 32'h0000_0000, 2'b00, 4'hF, 4'h0, 1'b0, 4'b0001, 1'b1, 1'b0, 32'h0, 8'd0);
    // Drive the counter to saturation with zero-wait slave errors
    for (int i = 0; i < 255; i++) begin
      step(1'b0, 32'h0000_0000, 2'b00, 4'hF, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 32'h1111_1111, i[7:0]);
    end
    step(1'b0, 32'h0000_0000, 2'b00, 4'hF, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 32'h1111_1111, 8'd255);
    step(1'b0, 32'h0000_0000, 2'b00, 4'hF, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, 32'h1111_1111, 8'd255);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge HCLK);
    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
